// File: rtl/spmem_pkj.sv
// Shared types for the sparse-memory request path.
package spmem_pkj;

    localparam int unsigned SPMEM_ADDR_W = 16;
    localparam int unsigned SPMEM_DATA_W = 32;

    // Default read latency of the sparse memory, sampling edge to data-valid.
    localparam int unsigned SPMEM_RD_LAT = 1;

    typedef logic [SPMEM_ADDR_W-1:0] addr_t;
    typedef logic [SPMEM_DATA_W-1:0] data_t;

    typedef enum logic {
        RWOP_DIS = 1'b0,
        RWOP_EN  = 1'b1
    } rwop_e;

endpackage

// File: rtl/spmem_rsp_fifo.sv
// Response FIFO for returning read data. The bridge's credit scheme
// guarantees it is never pushed when full nor popped when empty.
module spmem_rsp_fifo
    import spmem_pkj::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  data_t                   push_data_i,
    input  logic                    pop_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output data_t                   head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    data_t              mem_q [DEPTH];
    data_t              mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // Pointer, storage and occupancy update; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spmem_req_bridge.sv
// Request front-end for the sparse memory: credit-gated request acceptance,
// registered memory-side outputs, read-latency tracking and response buffering.
module spmem_req_bridge
    import spmem_pkj::*;
#(
    parameter int unsigned RD_LAT    = SPMEM_RD_LAT,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_write_i,
    input  addr_t        req_addr_i,
    input  data_t        req_wdata_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output data_t        rsp_rdata_o,
    output logic         cs_no,
    output rwop_e        we_o,
    output rwop_e        re_o,
    output addr_t        write_address_o,
    output addr_t        read_address_o,
    output data_t        write_data_o,
    input  data_t        read_data_i,
    output logic [15:0]  rd_count_o,
    output logic [15:0]  wr_count_o
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     used;
    logic [RD_LAT-1:0]  rd_vld_q, rd_vld_d;
    logic               cs_n_q, cs_n_d;
    rwop_e              we_q, we_d;
    rwop_e              re_q, re_d;
    addr_t              waddr_q, waddr_d;
    addr_t              raddr_q, raddr_d;
    data_t              wdata_q, wdata_d;
    logic [15:0]        rd_cnt_q, rd_cnt_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic               req_accept;
    logic               issue_rd;
    logic               issue_wr;
    logic               rd_mature;
    logic               rsp_pop;

    // Every outstanding read owns a FIFO slot from acceptance until it is popped,
    // so data returning under backpressure always has somewhere to land.
    assign used        = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_ready_o = !rst_i && (used < (CNT_W+1)'(RSP_DEPTH));
    assign req_accept  = req_valid_i && req_ready_o;
    assign issue_rd    = req_accept && !req_write_i;
    assign issue_wr    = req_accept && req_write_i;
    assign rd_mature   = rd_vld_q[RD_LAT-1];
    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    // Next memory-side command, latency tracking, in-flight tally and counters.
    always_comb begin
        cs_n_d   = 1'b1;
        we_d     = RWOP_DIS;
        re_d     = RWOP_DIS;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        wdata_d  = wdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        inflight_d = inflight_q;

        if (issue_wr) begin
            cs_n_d  = 1'b0;
            we_d    = RWOP_EN;
            waddr_d = req_addr_i;
            wdata_d = req_wdata_i;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (issue_rd) begin
            cs_n_d  = 1'b0;
            re_d    = RWOP_EN;
            raddr_d = req_addr_i;
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end

        // Stage 0 is set on the edge where the memory samples the read enable.
        rd_vld_d[0] = (re_q == RWOP_EN);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end

        case ({issue_rd, rd_mature})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset also drops any reads still in the latency pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_n_q     <= 1'b1;
            we_q       <= RWOP_DIS;
            re_q       <= RWOP_DIS;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= '0;
            rd_vld_q   <= '0;
        end else begin
            cs_n_q     <= cs_n_d;
            we_q       <= we_d;
            re_q       <= re_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wdata_q    <= wdata_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    spmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rd_mature),
        .push_data_i (read_data_i),
        .pop_i       (rsp_pop),
        .count_o     (fifo_count),
        .head_o      (rsp_rdata_o)
    );

    assign cs_no           = cs_n_q;
    assign we_o            = we_q;
    assign re_o            = re_q;
    assign write_address_o = waddr_q;
    assign read_address_o  = raddr_q;
    assign write_data_o    = wdata_q;
    assign rd_count_o      = rd_cnt_q;
    assign wr_count_o      = wr_cnt_q;

endmodule

// File: tb/tb_spmem_req_bridge.sv
// Bench for spmem_req_bridge: scenario tasks plus a request-level reference
// model (outstanding-read queue, memory image, saturating op counts).
module tb_spmem_req_bridge;
    import spmem_pkj::*;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned RSP_DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    addr_t       req_addr_i = '0;
    data_t       req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    data_t       rsp_rdata_o;
    logic        cs_no;
    rwop_e       we_o;
    rwop_e       re_o;
    addr_t       write_address_o;
    addr_t       read_address_o;
    data_t       write_data_o;
    data_t       read_data_i;
    logic [15:0] rd_count_o;
    logic [15:0] wr_count_o;

    int compared   = 0;
    int mismatched = 0;

    spmem_req_bridge #(
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_write_i     (req_write_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_rdata_o     (rsp_rdata_o),
        .cs_no           (cs_no),
        .we_o            (we_o),
        .re_o            (re_o),
        .write_address_o (write_address_o),
        .read_address_o  (read_address_o),
        .write_data_o    (write_data_o),
        .read_data_i     (read_data_i),
        .rd_count_o      (rd_count_o),
        .wr_count_o      (wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Sparse memory stand-in: samples the command at the rising edge, returns data RD_LAT later.
    data_t env_mem [addr_t];
    data_t rd_pipe [RD_LAT];
    always @(posedge clk_i) begin
        if (!cs_no && we_o == RWOP_EN) env_mem[write_address_o] = write_data_o;
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (!cs_no && re_o == RWOP_EN)
            rd_pipe[0] <= env_mem.exists(read_address_o) ? env_mem[read_address_o] : '0;
        else
            rd_pipe[0] <= data_t'($urandom);
    end
    assign read_data_i = rd_pipe[RD_LAT-1];

    // Reference model: request-level view of what the bridge must present.
    data_t       ref_mem [addr_t];
    data_t       exp_q [$];
    logic [15:0] m_rd, m_wr;
    logic        e_cs_n;
    rwop_e       e_we, e_re;
    addr_t       e_waddr, e_raddr;
    data_t       e_wdata;
    bit          mdl_on = 1'b0;
    logic        exp_rdy;

    always @(negedge clk_i) begin
        if (mdl_on) begin
            compared++;
            if ({cs_no, we_o, re_o} !== {e_cs_n, e_we, e_re}) begin
                mismatched++;
                $display("FAIL mon_cmd: got cs/we/re %b%b%b want %b%b%b t=%0t", cs_no, we_o, re_o, e_cs_n, e_we, e_re, $time);
            end
            compared++;
            if ({write_address_o, read_address_o, write_data_o} !== {e_waddr, e_raddr, e_wdata}) begin
                mismatched++;
                $display("FAIL mon_addr_data: got %h/%h/%h want %h/%h/%h t=%0t", write_address_o, read_address_o, write_data_o, e_waddr, e_raddr, e_wdata, $time);
            end
            exp_rdy = !rst_i && (exp_q.size() < RSP_DEPTH);
            compared++;
            if (req_ready_o !== exp_rdy) begin
                mismatched++;
                $display("FAIL mon_ready: got %b want %b t=%0t", req_ready_o, exp_rdy, $time);
            end
            compared++;
            if ({rd_count_o, wr_count_o} !== {m_rd, m_wr}) begin
                mismatched++;
                $display("FAIL mon_counts: got rd %h wr %h want rd %h wr %h t=%0t", rd_count_o, wr_count_o, m_rd, m_wr, $time);
            end
            if (!rst_i && rsp_valid_o === 1'b1 && exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL mon_spurious_rsp: got rsp_valid 1 want 0 t=%0t", $time);
            end
            if (!rst_i && rsp_valid_o === 1'b1 && rsp_ready_i && exp_q.size() > 0) begin
                compared++;
                if (rsp_rdata_o !== exp_q[0]) begin
                    mismatched++;
                    $display("FAIL mon_rsp_data: got %h want %h t=%0t", rsp_rdata_o, exp_q[0], $time);
                end
            end
            compared++;
            if (dut.used > RSP_DEPTH || dut.fifo_count > RSP_DEPTH) begin
                mismatched++;
                $display("FAIL mon_credit_bound: got used %0d fifo %0d want <= %0d t=%0t", dut.used, dut.fifo_count, RSP_DEPTH, $time);
            end
        end
        // Advance the model across the coming rising edge.
        if (rst_i) begin
            mdl_on  = 1'b1;
            exp_q.delete();
            m_rd    = '0;
            m_wr    = '0;
            e_cs_n  = 1'b1;
            e_we    = RWOP_DIS;
            e_re    = RWOP_DIS;
            e_waddr = '0;
            e_raddr = '0;
            e_wdata = '0;
        end else if (mdl_on) begin
            e_cs_n = 1'b1;
            e_we   = RWOP_DIS;
            e_re   = RWOP_DIS;
            if (rsp_valid_o === 1'b1 && rsp_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_valid_i && req_ready_o) begin
                e_cs_n = 1'b0;
                if (req_write_i) begin
                    e_we    = RWOP_EN;
                    e_waddr = req_addr_i;
                    e_wdata = req_wdata_i;
                    ref_mem[req_addr_i] = req_wdata_i;
                    if (m_wr != 16'hFFFF) m_wr++;
                end else begin
                    e_re    = RWOP_EN;
                    e_raddr = req_addr_i;
                    exp_q.push_back(ref_mem.exists(req_addr_i) ? ref_mem[req_addr_i] : '0);
                    if (m_rd != 16'hFFFF) m_rd++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        compared++;
        if ({cs_no, we_o, re_o, rsp_valid_o, req_ready_o} !== {1'b1, RWOP_DIS, RWOP_DIS, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_ctrl: got cs/we/re/rv/rdy %b%b%b%b%b want 10000", cs_no, we_o, re_o, rsp_valid_o, req_ready_o);
        end
        compared++;
        if ({write_address_o, read_address_o, write_data_o, rsp_rdata_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", write_address_o, read_address_o, write_data_o, rsp_rdata_o);
        end
        compared++;
        if ({rd_count_o, wr_count_o} !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_counts: got %h %h want 0 0", rd_count_o, wr_count_o);
        end
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if (req_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_write_read();
        tick();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 16'h0010;
        req_wdata_i = 32'h0000_A5A5;
        tick();
        req_write_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if ({cs_no, we_o, re_o, write_address_o, write_data_o} !== {1'b0, RWOP_EN, RWOP_DIS, 16'h0010, 32'h0000_A5A5}) begin
            mismatched++;
            $display("FAIL wr_cmd: got cs/we/re %b%b%b addr %h data %h want 010 0010 0000a5a5", cs_no, we_o, re_o, write_address_o, write_data_o);
        end
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if ({cs_no, we_o, re_o, read_address_o} !== {1'b0, RWOP_DIS, RWOP_EN, 16'h0010}) begin
            mismatched++;
            $display("FAIL rd_cmd: got cs/we/re %b%b%b addr %h want 001 0010", cs_no, we_o, re_o, read_address_o);
        end
        for (int k = 2; k < RD_LAT + 2; k++) begin
            tick();
            @(negedge clk_i);
            compared++;
            if ({cs_no, rsp_valid_o} !== 2'b10) begin
                mismatched++;
                $display("FAIL wr_rd_early: cycle %0d got cs %b rsp_valid %b want 1 0", k, cs_no, rsp_valid_o);
            end
        end
        tick();
        @(negedge clk_i);
        compared++;
        if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h0000_A5A5}) begin
            mismatched++;
            $display("FAIL wr_rd_rsp: got valid %b data %h want 1 0000a5a5", rsp_valid_o, rsp_rdata_o);
        end
        tick();
        rsp_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        compared++;
        if (rsp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL wr_rd_pop: got rsp_valid %b want 0", rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        tick();
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 16 + RD_LAT + 6; c++) begin
            req_valid_i = (c < 16);
            req_write_i = 1'b0;
            req_addr_i  = addr_t'($urandom_range(0, 15));
            @(negedge clk_i);
            if (c < 16) begin
                compared++;
                if (req_ready_o !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_ready: read %0d got ready %b want 1", c, req_ready_o);
                end
            end
            if (rsp_valid_o && rsp_ready_i) got++;
            tick();
        end
        req_valid_i = 1'b0;
        compared++;
        if (got != 16) begin
            mismatched++;
            $display("FAIL b2b_responses: got %0d want 16", got);
        end
    endtask

    task automatic test_backpressure();
        data_t wv [8];
        int    acc = 0;
        int    got = 0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wv[i]       = data_t'($urandom);
            req_valid_i = 1'b1;
            req_write_i = 1'b1;
            req_addr_i  = addr_t'(16'h0040 + i);
            req_wdata_i = wv[i];
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = addr_t'(16'h0040 + acc);
            @(negedge clk_i);
            if (req_ready_o) acc++;
            tick();
        end
        req_valid_i = 1'b0;
        compared++;
        if (acc != 4) begin
            mismatched++;
            $display("FAIL bp_accepted: got %0d want 4", acc);
        end
        @(negedge clk_i);
        compared++;
        if (req_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_stalled: got ready %b want 0", req_ready_o);
        end
        tick();
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            req_valid_i = (acc < 8);
            req_write_i = 1'b0;
            req_addr_i  = addr_t'(16'h0040 + acc);
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) begin
                compared++;
                if (rsp_rdata_o !== wv[got]) begin
                    mismatched++;
                    $display("FAIL bp_order: resp %0d got %h want %h", got, rsp_rdata_o, wv[got]);
                end
                got++;
            end
            if (req_valid_i && req_ready_o) acc++;
            tick();
        end
        req_valid_i = 1'b0;
        compared++;
        if (got != 8) begin
            mismatched++;
            $display("FAIL bp_drained: got %0d want 8", got);
        end
    endtask

    task automatic test_pop_issue_full();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = addr_t'(16'h0020 + i);
            tick();
        end
        req_addr_i = 16'h0030;
        repeat (RD_LAT + 1) tick();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        compared++;
        if ({req_ready_o, rsp_valid_o} !== 2'b01) begin
            mismatched++;
            $display("FAIL pif_before_pop: got ready %b rsp_valid %b want 0 1", req_ready_o, rsp_valid_o);
        end
        tick();
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if (req_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL pif_after_pop: got ready %b want 1", req_ready_o);
        end
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if (req_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL pif_refull: got ready %b want 0", req_ready_o);
        end
        tick();
        rsp_ready_i = 1'b1;
        repeat (RD_LAT + 8) tick();
        @(negedge clk_i);
        compared++;
        if (rsp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL pif_drain: got rsp_valid %b want 0", rsp_valid_o);
        end
    endtask

    task automatic test_reset_inflight();
        tick();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 16'h0041;
        tick();
        req_addr_i  = 16'h0042;
        tick();
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        tick();
        rst_i       = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            compared++;
            if ({rsp_valid_o, cs_no, req_ready_o, rd_count_o} !== {3'b011, 16'h0000}) begin
                mismatched++;
                $display("FAIL rst_inflight: cycle %0d got rv/cs/rdy %b%b%b rd_count %h want 011 0000", c, rsp_valid_o, cs_no, req_ready_o, rd_count_o);
            end
            tick();
        end
        rsp_ready_i = 1'b1;
    endtask

    task automatic test_random();
        int nrd = 0;
        int nwr = 0;
        for (int c = 0; c < 300; c++) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_write_i = 1'($urandom_range(0, 1));
            req_addr_i  = addr_t'($urandom_range(0, 15));
            req_wdata_i = data_t'($urandom);
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk_i);
            if (req_valid_i && req_ready_o) begin
                if (req_write_i) nwr++;
                else nrd++;
            end
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || rsp_valid_o); c++) tick();
        @(negedge clk_i);
        compared++;
        if (rsp_valid_o !== 1'b0 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL random_drain: got rsp_valid %b outstanding %0d want 0 0", rsp_valid_o, exp_q.size());
        end
        compared++;
        if ({rd_count_o, wr_count_o} !== {16'(nrd), 16'(nwr)}) begin
            mismatched++;
            $display("FAIL random_counts: got rd %0d wr %0d want rd %0d wr %0d", rd_count_o, wr_count_o, nrd, nwr);
        end
    endtask

    task automatic test_saturation();
        tick();
        force dut.rd_cnt_q = 16'hFFFE;
        m_rd = 16'hFFFE;
        tick();
        release dut.rd_cnt_q;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = addr_t'(i);
            tick();
            @(negedge clk_i);
            compared++;
            if (rd_count_o !== 16'hFFFF) begin
                mismatched++;
                $display("FAIL sat_rd_count: read %0d got %h want ffff", i, rd_count_o);
            end
        end
        req_valid_i = 1'b0;
        repeat (RD_LAT + 4) tick();
        @(negedge clk_i);
        compared++;
        if (rd_count_o !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL sat_hold: got %h want ffff", rd_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_pop_issue_full();
        test_reset_inflight();
        test_random();
        test_saturation();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spmem_req_bridge.md
# spmem_req_bridge

Request front-end for the sparse memory. It accepts a single valid/ready request stream of reads and writes and issues at most one operation per cycle on the sparse-memory port through registered outputs. Read data returns after a fixed latency. The bridge captures it into a response FIFO that is credit-protected, so read data is never dropped while the response sink applies backpressure. It sits directly upstream of the sparse memory and drives that block's `cs_ni`, `we_i`, `re_i`, address and data inputs.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from the memory sampling `re` to `read_data_i` being valid. Legal range 1..4.
- `RSP_DEPTH`, default 2: response FIFO entries. Power of two, at least 2.

Ports. One clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i` and `req_ready_o` are both high at a rising edge.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  `addr_t`  request address.
- `req_wdata_i`  in  `data_t`  write data; ignored for reads.
- `rsp_valid_o`  out  1  read response valid.
- `rsp_ready_i`  in  1  response sink ready.
- `rsp_rdata_o`  out  `data_t`  read data, in issue order.
- `cs_no`  out  1  memory chip select, active low.
- `we_o`, `re_o`  out  `rwop_e`  memory write and read enables.
- `write_address_o`, `read_address_o`  out  `addr_t`  memory addresses.
- `write_data_o`  out  `data_t`  memory write data.
- `read_data_i`  in  `data_t`  memory read data.
- `rd_count_o`, `wr_count_o`  out  16  accepted reads and writes; saturate at 16'hFFFF.

## Operation
- Credits: `used = inflight + fifo_count`, both taken from registers. `req_ready_o = !rst_i && (used < RSP_DEPTH)`.
  - Writes also consume the check, which keeps ordering simple.
  - `req_ready_o` never depends combinationally on `rsp_ready_i` or on the request payload.
- Accepted write:
  - Next cycle drives `cs_no=0`, `we_o` = enable literal, `re_o` = disable literal, `write_address_o=req_addr_i`, `write_data_o=req_wdata_i`.
- Accepted read:
  - Next cycle drives `cs_no=0`, `re_o` = enable literal, `we_o` = disable literal, `read_address_o=req_addr_i`.
  - `inflight` increments.
- No acceptance: next cycle `cs_no=1` and both enables at the disable literal. Addresses and write data hold their last values.
- Return path: an `RD_LAT`-deep valid shift register tracks issued reads.
  - When a tagged slot matures, `read_data_i` is pushed into the FIFO and `inflight` decrements.
- The FIFO pops on `rsp_valid_o && rsp_ready_i`. `rsp_valid_o = fifo_count != 0`. `rsp_rdata_o` is the head entry.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged.
  - Issue and maturing read in the same cycle: `inflight` is unchanged.
  - A pop frees a credit only from the next cycle.
- Overflow is impossible by construction. The bench asserts `fifo_count <= RSP_DEPTH` and `used <= RSP_DEPTH`.
- Counters increment on each accepted operation and stick at 16'hFFFF.

## Timing
- Handshake at edge N:
  - Memory-side outputs are valid during cycle N..N+1 and sampled by the memory at edge N+1.
  - For reads, data is captured at edge N+1+`RD_LAT`.
  - `rsp_valid_o` is high from that edge onward.
- Throughput: one op per cycle while credits allow. With `RSP_DEPTH` >= `RD_LAT`+2 and `rsp_ready_i=1`, back-to-back reads sustain 100%.
- Reset (any cycle, including mid-operation): `cs_no=1`, enables = disable literal, addresses and write data = 0, `rsp_valid_o=0`, `rsp_rdata_o=0`, counters = 0, `inflight=0`, FIFO empty, valid shift register cleared.
  - Reads in flight at reset are discarded. Their late `read_data_i` is ignored.
  - `req_ready_o=0` while `rst_i=1`, and 1 in the first cycle after release.

## Structure
- Shared package `spmem_pkj` holds `addr_t`, `data_t`, `rwop_e`, and a new `SPMEM_RD_LAT` constant used as the default for `RD_LAT`.
- One sub-module: `spmem_rsp_fifo`, a synchronous FIFO with parameter `DEPTH`, push/pop, count and head data, reset by `rst_i`.
- The credit logic, shift register, output registers and counters live in `spmem_req_bridge`.

## Test plan
- Write 0xA5A5 to address 0x10, then read 0x10 on the next cycle. `cs_no` is low for two consecutive cycles, and `rsp_rdata_o=0xA5A5` appears `RD_LAT`+2 cycles after the write handshake.
- Eight back-to-back reads with `RSP_DEPTH=4`, `RD_LAT=1`, and `rsp_ready_i=0`: exactly 4 are accepted, then `req_ready_o=0`. Raising `rsp_ready_i` drains the responses in address order with no loss.
- Pop and issue in the same cycle with the FIFO full: `req_ready_o` rises only one cycle after the pop.
- Assert `rst_i` for one cycle while 2 reads are in flight: no `rsp_valid_o` afterwards, `rd_count_o=0`, `cs_no=1`, and `req_ready_o=1` after release.
- Preload `rd_count_o` to 16'hFFFE through 65534 reads (or a force), then perform 3 more reads: the count reads 16'hFFFF and holds.
